// File: rtl/uart_receiver.sv
`timescale 1ns/1ps
// Purpose    : 8-bit UART receiver, 16x NCO oversampling, 3-sample majority vote, optional parity.
// Latency    : data_valid rises 1 clk after the mid-bit decision of the last stop bit.
// Backpressure: one-byte holding register; a good byte arriving while data_valid=1 (no ack) is dropped with overrun_err.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   rxd         asynchronous serial input, idles high
//   data        received byte (holding register)
//   data_valid  holding register holds an unread byte
//   data_ack    consumer has read data; clears data_valid next clk
//   busy        a frame is in progress (any state but IDLE)
//   frame_err   one-cycle pulse: a stop bit was sampled low
//   parity_err  one-cycle pulse: parity mismatch
//   overrun_err one-cycle pulse: good byte completed while data_valid=1

module uart_receiver #(
  parameter int SYS_CLK     = 50000000,
  parameter int DEFAULT_BDR = 115200,
  parameter int PARITY_BIT  = 0,       // 0 none, 1 even, 2 odd
  parameter int STOP_BIT    = 2        // stop bits checked, 1 or 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ack,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun_err
);

  // Phase increment for a tick rate of 16x the baud rate on a 16-bit phase.
  localparam longint INC_L = (longint'(DEFAULT_BDR) * 1048576) / longint'(SYS_CLK);
  localparam logic [15:0] INC = 16'(INC_L);

  generate
    if (INC_L <= 0 || INC_L >= 65536) begin : g_bad_inc
      $error("uart_receiver: baud increment out of range for SYS_CLK/DEFAULT_BDR");
    end
    if (STOP_BIT < 1 || STOP_BIT > 2) begin : g_bad_stop
      $error("uart_receiver: STOP_BIT must be 1 or 2");
    end
    if (PARITY_BIT < 0 || PARITY_BIT > 2) begin : g_bad_par
      $error("uart_receiver: PARITY_BIT must be 0, 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // Synchronizer and edge-detect history
  logic        r_rx_meta;
  logic        r_rxs;
  logic        r_rxs_d;

  // Baud NCO and oversample position
  logic [16:0] r_acc;
  logic [3:0]  r_os;
  logic [1:0]  r_samp;     // [1] = sample at os 7, [0] = sample at os 8

  // Frame state
  state_t      r_state;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_par_err;
  logic        r_frm_err;
  logic        r_stop_idx;

  // Registered outputs
  logic [7:0]  r_data;
  logic        r_vld;
  logic        r_busy;
  logic        r_ferr;
  logic        r_perr;
  logic        r_ovr;

  logic        w_tick;
  logic        w_start_edge;
  logic        w_decide;
  logic        w_bit;
  logic        w_stop_err;
  logic        w_last_stop;
  logic        w_par_calc;
  logic        w_par_bad;

  // Bit 16 is set only in the cycle after the 16-bit phase wraps, so it is
  // already a one-cycle registered pulse.
  assign w_tick       = r_acc[16];
  assign w_start_edge = (r_state == S_IDLE) && r_rxs_d && !r_rxs;
  assign w_decide     = w_tick && (r_os == 4'd9);

  // The third vote is the live synchronized value on the os = 9 tick.
  assign w_bit = (r_samp[1] & r_samp[0]) | (r_samp[1] & r_rxs) | (r_samp[0] & r_rxs);

  // A low stop bit seen earlier in the frame is remembered in r_frm_err.
  assign w_stop_err  = r_frm_err | ~w_bit;
  assign w_last_stop = (r_stop_idx == 1'(STOP_BIT - 1));

  assign w_par_calc = (^r_shift) ^ w_bit;
  assign w_par_bad  = (PARITY_BIT == 2) ? ~w_par_calc : w_par_calc;

  // 2-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
      r_rxs_d   <= 1'b1;
    end else begin
      r_rx_meta <= rxd;
      r_rxs     <= r_rx_meta;
      r_rxs_d   <= r_rxs;
    end
  end

  // NCO, oversample counter and mid-bit sample registers. Clearing on the
  // start edge aligns sample points to the received frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= 17'd0;
      r_os   <= 4'd0;
      r_samp <= 2'b11;
    end else if (w_start_edge) begin
      r_acc  <= 17'd0;
      r_os   <= 4'd0;
    end else begin
      r_acc <= {1'b0, r_acc[15:0]} + {1'b0, INC};
      if (w_tick) begin
        r_os <= r_os + 4'd1;
        if (r_os == 4'd7 || r_os == 4'd8) begin
          r_samp <= {r_samp[0], r_rxs};
        end
      end
    end
  end

  // Frame FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'd0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_stop_idx <= 1'b0;
      r_data     <= 8'd0;
      r_vld      <= 1'b0;
      r_busy     <= 1'b0;
      r_ferr     <= 1'b0;
      r_perr     <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      r_perr <= 1'b0;
      r_ovr  <= 1'b0;

      // Ack consumes the held byte; a byte loaded below in the same cycle wins.
      if (data_ack && r_vld) begin
        r_vld <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (w_decide) begin
            if (w_bit) begin
              // Line back high at mid start bit: treat as a glitch.
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= S_DATA;
              r_bit_idx <= 3'd0;
              r_par_err <= 1'b0;
              r_frm_err <= 1'b0;
            end
          end
        end

        S_DATA: begin
          if (w_decide) begin
            r_shift <= {w_bit, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_stop_idx <= 1'b0;
              r_state    <= (PARITY_BIT != 0) ? S_PARITY : S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end

        S_PARITY: begin
          if (w_decide) begin
            r_par_err <= w_par_bad;
            r_state   <= S_STOP;
          end
        end

        S_STOP: begin
          if (w_decide) begin
            if (!w_last_stop) begin
              r_frm_err  <= w_stop_err;
              r_stop_idx <= r_stop_idx + 1'b1;
            end else if (w_stop_err) begin
              // Line may be in break; hold off new frames until it idles.
              r_ferr  <= 1'b1;
              r_state <= S_WAIT_HIGH;
            end else if (r_par_err) begin
              r_perr  <= 1'b1;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else if (r_vld && !data_ack) begin
              // Old unread byte is kept, new byte is dropped.
              r_ovr   <= 1'b1;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_data  <= r_shift;
              r_vld   <= 1'b1;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end

        S_WAIT_HIGH: begin
          if (r_rxs) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data        = r_data;
  assign data_valid  = r_vld;
  assign busy        = r_busy;
  assign frame_err   = r_ferr;
  assign parity_err  = r_perr;
  assign overrun_err = r_ovr;

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
// Purpose    : scoreboard bench for uart_receiver (default, even-parity and loopback instances).
// Latency    : expected events queued at stimulus time, popped by a negedge monitor.
// Backpressure: data_ack driven by stimulus; unread bytes exercise the overrun path.

module tb_uart_receiver;

  localparam int BIT0 = 434;   // clk per bit at 115200 baud / 50 MHz
  localparam int BITF = 108;   // clk per bit at 460800 baud / 50 MHz

  localparam int K_DATA = 0;
  localparam int K_FERR = 1;
  localparam int K_PERR = 2;
  localparam int K_OVR  = 3;

  typedef struct {
    int       dut;
    int       kind;
    logic [7:0] d;
    logic     v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd_v  [3];
  logic       ack_v  [3];
  logic [7:0] dat_v  [3];
  logic       vld_v  [3];
  logic       busy_v [3];
  logic       ferr_v [3];
  logic       perr_v [3];
  logic       ovr_v  [3];
  logic       pv     [3];
  logic [7:0] pd     [3];

  always #10 clk = ~clk;

  // 0: default parameters
  uart_receiver u_main (
    .clk(clk), .rst(rst), .rxd(rxd_v[0]), .data(dat_v[0]), .data_valid(vld_v[0]),
    .data_ack(ack_v[0]), .busy(busy_v[0]), .frame_err(ferr_v[0]),
    .parity_err(perr_v[0]), .overrun_err(ovr_v[0])
  );

  // 1: even parity, one stop bit, fast baud
  uart_receiver #(.SYS_CLK(50000000), .DEFAULT_BDR(460800), .PARITY_BIT(1), .STOP_BIT(1)) u_par (
    .clk(clk), .rst(rst), .rxd(rxd_v[1]), .data(dat_v[1]), .data_valid(vld_v[1]),
    .data_ack(ack_v[1]), .busy(busy_v[1]), .frame_err(ferr_v[1]),
    .parity_err(perr_v[1]), .overrun_err(ovr_v[1])
  );

  // 2: no parity, two stop bits, fast baud; fed by the transmitter model
  uart_receiver #(.SYS_CLK(50000000), .DEFAULT_BDR(460800), .PARITY_BIT(0), .STOP_BIT(2)) u_lb (
    .clk(clk), .rst(rst), .rxd(rxd_v[2]), .data(dat_v[2]), .data_valid(vld_v[2]),
    .data_ack(ack_v[2]), .busy(busy_v[2]), .frame_err(ferr_v[2]),
    .parity_err(perr_v[2]), .overrun_err(ovr_v[2])
  );

  function automatic exp_t mk(input int dut, input int kind, input logic [7:0] d, input logic v);
    exp_t e;
    e.dut  = dut;
    e.kind = kind;
    e.d    = d;
    e.v    = v;
    return e;
  endfunction

  task automatic sb_check(input int i, input int kind);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL sb_unexpected: dut%0d event %0d data 0x%02h vld %0b, nothing expected",
               i, kind, dat_v[i], vld_v[i]);
    end else begin
      e = sb.pop_front();
      if (e.dut != i || e.kind != kind || dat_v[i] !== e.d || vld_v[i] !== e.v) begin
        n_bad++;
        $display("FAIL sb_event: got dut%0d kind %0d data 0x%02h vld %0b, expected dut%0d kind %0d data 0x%02h vld %0b",
                 i, kind, dat_v[i], vld_v[i], e.dut, e.kind, e.d, e.v);
      end
    end
  endtask

  // Monitor: a new byte is a rising data_valid, or a data change while valid stays high.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        if (vld_v[i] && (!pv[i] || dat_v[i] != pd[i])) sb_check(i, K_DATA);
        if (ferr_v[i]) sb_check(i, K_FERR);
        if (perr_v[i]) sb_check(i, K_PERR);
        if (ovr_v[i])  sb_check(i, K_OVR);
      end
      pv[i] <= vld_v[i];
      pd[i] <= dat_v[i];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives start, 8 data bits LSB first, optional parity slot, then leaves
  // the line at stop_lvl and returns at the start of the stop bit.
  task automatic send_frame(input int i, input logic [7:0] d, input bit has_p, input logic p,
                            input logic stop_lvl, input int bt);
    rxd_v[i] = 1'b0;
    idle(bt);
    for (int k = 0; k < 8; k++) begin
      rxd_v[i] = d[k];
      idle(bt);
    end
    if (has_p) begin
      rxd_v[i] = p;
      idle(bt);
    end
    rxd_v[i] = stop_lvl;
  endtask

  task automatic wait_vld(input int i, input int lim, output int t);
    t = 0;
    while (!vld_v[i] && t < lim) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (!vld_v[i]) begin
      n_bad++;
      $display("FAIL vld_timeout: dut%0d data_valid still 0 after %0d clk", i, lim);
    end
  endtask

  task automatic wait_drain(input int lim);
    int t = 0;
    while (sb.size() != 0 && t < lim) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected events, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic ack_pulse(input int i);
    ack_v[i] = 1'b1;
    idle(1);
    ack_v[i] = 1'b0;
    chk("ack_clears_valid", int'(vld_v[i]), 0);
  endtask

  // Transmitter model: 8 data bits, '1' in the parity slot, 2 stop bits.
  task automatic tx_model(input int i, input logic [7:0] d, input int bt);
    send_frame(i, d, 1'b1, 1'b1, 1'b1, bt);
    idle(2 * bt);
  endtask

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: cycle budget exhausted");
    $fatal(1, "tb_uart_receiver watchdog");
  end

  initial begin
    int t;
    int t_done;
    logic [7:0] lb_bytes [3];
    logic [7:0] rbyte;
    lb_bytes[0] = 8'h00;
    lb_bytes[1] = 8'hFF;
    lb_bytes[2] = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      rxd_v[i] = 1'b1;
      ack_v[i] = 1'b0;
    end
    rst = 1'b1;
    idle(5);
    rst = 1'b0;
    idle(2);

    // Reset state
    chk("rst_data", int'(dat_v[0]), 0);
    chk("rst_valid", int'(vld_v[0]), 0);
    chk("rst_busy", int'(busy_v[0]), 0);
    chk("rst_frame_err", int'(ferr_v[0]), 0);
    chk("rst_parity_err", int'(perr_v[0]), 0);
    chk("rst_overrun_err", int'(ovr_v[0]), 0);

    // 0xA5, ack 5 clk after valid
    sb.push_back(mk(0, K_DATA, 8'hA5, 1'b1));
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, BIT0);
      wait_vld(0, 12 * BIT0, t);
    join
    chk_rng("a5_latency", t, 10 * BIT0, 11 * BIT0);
    idle(5);
    ack_pulse(0);
    chk("a5_data_hold", int'(dat_v[0]), 8'hA5);
    wait_drain(1);
    idle(2 * BIT0);

    // Glitch shorter than 7/16 bit
    rxd_v[0] = 1'b0;
    idle(50);
    chk("glitch_busy", int'(busy_v[0]), 1);
    idle(50);
    rxd_v[0] = 1'b1;
    idle(BIT0);
    chk("glitch_idle", int'(busy_v[0]), 0);
    chk("glitch_no_valid", int'(vld_v[0]), 0);

    sb.push_back(mk(0, K_DATA, 8'h3C, 1'b1));
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, BIT0);
    wait_drain(3 * BIT0);
    ack_pulse(0);
    idle(BIT0);

    // Frame error: stop low, line held low 3 bit-times
    sb.push_back(mk(0, K_FERR, 8'h3C, 1'b0));
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, BIT0);
    idle(2 * BIT0);
    chk("ferr_busy_low", int'(busy_v[0]), 1);
    wait_drain(BIT0);
    idle(BIT0);
    chk("ferr_busy_still_low", int'(busy_v[0]), 1);
    rxd_v[0] = 1'b1;
    idle(5);
    chk("ferr_busy_after_high", int'(busy_v[0]), 0);
    chk("ferr_no_valid", int'(vld_v[0]), 0);
    idle(BIT0);

    sb.push_back(mk(0, K_DATA, 8'h81, 1'b1));
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, BIT0);
    wait_drain(3 * BIT0);
    ack_pulse(0);
    idle(BIT0);

    // Overrun: 0x11 then 0x22 back-to-back, no ack
    sb.push_back(mk(0, K_DATA, 8'h11, 1'b1));
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, BIT0);
    idle(2 * BIT0);
    sb.push_back(mk(0, K_OVR, 8'h11, 1'b1));
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, BIT0);
    wait_drain(3 * BIT0);
    chk("ovr_data_kept", int'(dat_v[0]), 8'h11);
    chk("ovr_valid_kept", int'(vld_v[0]), 1);
    idle(BIT0);
    ack_pulse(0);
    idle(BIT0);

    // Same pair, ack timed onto the second completion cycle. The completion
    // offset is measured on the first frame; frames are phase-aligned to the start edge.
    sb.push_back(mk(0, K_DATA, 8'h11, 1'b1));
    fork
      send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, BIT0);
      wait_vld(0, 12 * BIT0, t_done);
    join
    idle(11 * BIT0 - t_done);
    sb.push_back(mk(0, K_DATA, 8'h22, 1'b1));
    fork
      send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, BIT0);
      begin
        idle(t_done - 1);
        ack_v[0] = 1'b1;
        idle(1);
        ack_v[0] = 1'b0;
      end
    join
    wait_drain(3 * BIT0);
    chk("ack_same_cycle_data", int'(dat_v[0]), 8'h22);
    chk("ack_same_cycle_valid", int'(vld_v[0]), 1);
    idle(BIT0);

    // Reset during data bit 3 of 0x5A
    rbyte = 8'h5A;
    rxd_v[0] = 1'b0;
    idle(BIT0);
    for (int k = 0; k < 3; k++) begin
      rxd_v[0] = rbyte[k];
      idle(BIT0);
    end
    rxd_v[0] = rbyte[3];
    idle(BIT0 / 2);
    chk("pre_rst_busy", int'(busy_v[0]), 1);
    rst = 1'b1;
    rxd_v[0] = 1'b1;
    idle(1);
    chk("mid_rst_data", int'(dat_v[0]), 0);
    chk("mid_rst_valid", int'(vld_v[0]), 0);
    chk("mid_rst_busy", int'(busy_v[0]), 0);
    chk("mid_rst_errs", int'({ferr_v[0], perr_v[0], ovr_v[0]}), 0);
    rst = 1'b0;
    idle(BIT0);
    chk("post_rst_idle", int'(busy_v[0]), 0);

    sb.push_back(mk(0, K_DATA, 8'hF0, 1'b1));
    send_frame(0, 8'hF0, 1'b0, 1'b0, 1'b1, BIT0);
    wait_drain(3 * BIT0);
    ack_pulse(0);
    idle(2 * BIT0);

    // Even parity: 0x07 has three ones, so p=1 is correct, p=0 is not
    sb.push_back(mk(1, K_DATA, 8'h07, 1'b1));
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, BITF);
    wait_drain(3 * BITF);
    idle(BITF);
    sb.push_back(mk(1, K_PERR, 8'h07, 1'b1));
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, BITF);
    wait_drain(3 * BITF);
    chk("perr_data_unchanged", int'(dat_v[1]), 8'h07);
    chk("perr_valid_kept", int'(vld_v[1]), 1);
    idle(BITF);

    // Loopback from the transmitter model, frames back-to-back
    for (int b = 0; b < 3; b++) begin
      sb.push_back(mk(2, K_DATA, lb_bytes[b], 1'b1));
      fork
        tx_model(2, lb_bytes[b], BITF);
        begin
          wait_vld(2, 13 * BITF, t);
          ack_v[2] = 1'b1;
          idle(1);
          ack_v[2] = 1'b0;
        end
      join
    end
    wait_drain(2 * BITF);
    idle(BITF);

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL final_queue: got %0d pending expected events, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
